seg_counter_mux: RTL and testbench
==================================

Name: seg_counter_mux

Overview:
- Parametrised multi-digit counter with scanned, time-multiplexed 7-segment output; next generation of the single-digit auto-counting segment display.
- Adds a count-rate prescaler, up/down counting, synchronous load, enable, selectable base (decimal or hex), a digit-scan driver and a wrap pulse.
- Sits between the system clock domain and a common-segment, digit-multiplexed LED display.

Parameters:
- DIGITS, 4, number of displayed digits, 1..8.
- BASE, 10, per-digit radix, 2..16.
- TICK_DIV, 4, clock cycles per count step when enabled, ≥1.
- SCAN_DIV, 2, clock cycles each digit stays selected, ≥1.
- ACTIVE_LOW, 0, 1 inverts segment and digit_sel outputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  count enable.
- up  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  packed nibbles; digit 0 in [3:0].
- value  out  4*DIGITS  current count, packed nibbles.
- segment  out  7  {g,f,e,d,c,b,a} of the selected digit.
- digit_sel  out  DIGITS  one-hot digit enable.
- wrap  out  1  one-cycle pulse on full-range wrap.

Behaviour:
- Reset (async, immediate): value=0, prescaler=0, scan index=0, wrap=0, digit_sel=one-hot bit 0, segment=decode(0)=7'h3F. ACTIVE_LOW inversion applies to both outputs during reset.
- Prescaler: counts 0..TICK_DIV-1 while en=1. Internal tick is asserted in the cycle where prescaler==TICK_DIV-1 and en=1; prescaler returns to 0 after the tick. en=0 holds the prescaler. TICK_DIV=1 gives a tick every enabled cycle.
- Priority: load > tick. When load=1, value<=load_val, prescaler<=0, wrap<=0, and any coincident tick is discarded.
- Up step: digit 0 increments.
  - A digit at BASE-1 becomes 0 and carries into the next digit.
  - Carry ripples in the same cycle, so value updates on the tick edge (latency 1).
- Down step: a digit at 0 becomes BASE-1 and borrows from the next digit.
- Out-of-range digits: loaded nibbles ≥BASE are accepted as-is. On up, such a digit is treated as BASE-1 (→0, carry). On down it decrements normally.
- wrap: high for exactly the cycle after a tick that carries or borrows out of digit DIGITS-1, for example 99→00 up or 00→99 down with DIGITS=2, BASE=10. Otherwise 0.
- Direction: up is sampled only on tick edges. Changing up between ticks has no other effect.
- Scan: a free-running scan counter runs independently of en and load. The scan index advances every SCAN_DIV cycles and wraps DIGITS-1→0.
- Scan outputs: digit_sel and segment are registered and update on the same edge.
  - segment shows decode of the value nibble at the new index, as held before that edge.
  - Display of a new count therefore lags value by ≤1 cycle.
- Decode table, active-high: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- DIGITS=1: digit_sel is constantly 1 and the scan counter is optimised away.
- Reset asserted mid-operation overrides everything, including a pending load or tick. Counting resumes on the first enabled cycle after deassertion, with a full TICK_DIV cycles before the first tick.

Decomposition:
- Package seg_pkg: 16-entry 7-segment decode constant table, decode function, nibble width constant (4).
- One sub-module seg7_decoder: combinational nibble→7-bit, with ACTIVE_LOW parameter.
- Prescaler, BCD/radix counter chain and scan logic stay in seg_counter_mux.

Test Plan:
- Bench configuration for all cases: DIGITS=2, BASE=10, TICK_DIV=2, SCAN_DIV=1 unless noted.
- Reset then en=1, up=1 for 20 cycles → value steps 00,01,…,0x0A→ shown as 10 (nibbles 1,0) every 2 cycles; digit_sel alternates 01/10 each cycle; segment=06 when digit 1 selected, 3F when digit 0 selected.
- load_val=0x98, en=1, up=1 → after 2 ticks value=0x00; wrap high exactly one cycle after the 99→00 tick; no wrap at 98→99.
- Load 0x00, up=0, en=1 → first tick gives 0x99 with a wrap pulse; next tick gives 0x98 with no wrap.
- load=1 with load_val=0x42 in the cycle a tick is due → value=0x42 and prescaler restarts; next change to 0x43 occurs 2 enabled cycles later. Then en=0 for 10 cycles → value held at 0x43 while scanning continues.
- Assert rst asynchronously mid-count at value 0x57 (between clock edges) → value=0, digit_sel=01, segment=3F immediately, before the next edge. ACTIVE_LOW=1 run → segment=40 and digit_sel=10 (inverted) during reset.
- BASE=16, load_val=0xFE, up=1 → values FE, FF, 00 with wrap; segment shows 71 for F and 79 for E on the matching digit slots.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: nibble width, active-high glyph table and lookup.
// Segment bit order is {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int NIBBLE_W = 4;

    // Entry 15 sits in the top slice, entry 0 in the bottom slice.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_decode(input logic [NIBBLE_W-1:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble to 7-segment decoder with optional output inversion.
module seg7_decoder
    import seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [6:0]          segment
);

    always_comb begin
        segment = ACTIVE_LOW ? ~seg_decode(nibble) : seg_decode(nibble);
    end

endmodule

// File: rtl/seg_counter_mux.sv
// Multi-digit up/down radix counter with prescaled stepping, load, wrap pulse
// and a registered, time-multiplexed 7-segment digit scanner.
module seg_counter_mux
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int BASE       = 10,
    parameter int TICK_DIV   = 4,
    parameter int SCAN_DIV   = 2,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         up,
    input  logic                         load,
    input  logic [NIBBLE_W*DIGITS-1:0]   load_val,
    output logic [NIBBLE_W*DIGITS-1:0]   value,
    output logic [6:0]                   segment,
    output logic [DIGITS-1:0]            digit_sel,
    output logic                         wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]       PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [NIBBLE_W-1:0] DIGIT_MAX  = NIBBLE_W'(BASE - 1);

    logic [PW-1:0]                 presc;
    logic                          tick;
    logic [NIBBLE_W*DIGITS-1:0]    value_next;
    logic                          carry;
    logic                          carry_out;
    logic [IW-1:0]                 idx_next;
    logic [NIBBLE_W-1:0]           shown_nib;
    logic [DIGITS-1:0]             sel_onehot;

    assign tick = en && (presc == PRESC_LAST);

    // Ripple carry/borrow through every digit; out-of-range digits wrap like BASE-1 going up.
    always_comb begin
        value_next = value;
        carry      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (up) begin
                    if (value[i*NIBBLE_W +: NIBBLE_W] >= DIGIT_MAX) begin
                        value_next[i*NIBBLE_W +: NIBBLE_W] = '0;
                    end else begin
                        value_next[i*NIBBLE_W +: NIBBLE_W] = value[i*NIBBLE_W +: NIBBLE_W] + 1'b1;
                        carry = 1'b0;
                    end
                end else begin
                    if (value[i*NIBBLE_W +: NIBBLE_W] == '0) begin
                        value_next[i*NIBBLE_W +: NIBBLE_W] = DIGIT_MAX;
                    end else begin
                        value_next[i*NIBBLE_W +: NIBBLE_W] = value[i*NIBBLE_W +: NIBBLE_W] - 1'b1;
                        carry = 1'b0;
                    end
                end
            end
        end
        carry_out = carry;
    end

    // Load wins over a coincident tick and restarts the prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            presc <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            value <= load_val;
            presc <= '0;
            wrap  <= 1'b0;
        end else begin
            if (en) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
            if (tick) begin
                value <= value_next;
            end
            wrap <= tick && carry_out;
        end
    end

    generate
        if (DIGITS > 1) begin : g_scan
            logic [SW-1:0] scan_cnt;
            logic [IW-1:0] scan_idx;
            logic          scan_step;

            assign scan_step = (scan_cnt == SW'(SCAN_DIV - 1));

            always_comb begin
                idx_next = scan_idx;
                if (scan_step) begin
                    idx_next = (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    scan_cnt <= '0;
                    scan_idx <= '0;
                end else begin
                    scan_cnt <= scan_step ? '0 : scan_cnt + 1'b1;
                    scan_idx <= idx_next;
                end
            end
        end else begin : g_fixed
            assign idx_next = '0;
        end
    endgenerate

    // Display registers sample the pre-edge count at the index taking effect on this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shown_nib  <= '0;
            sel_onehot <= DIGITS'(1);
        end else begin
            shown_nib  <= value[idx_next*NIBBLE_W +: NIBBLE_W];
            sel_onehot <= DIGITS'(1) << idx_next;
        end
    end

    assign digit_sel = ACTIVE_LOW ? ~sel_onehot : sel_onehot;

    seg7_decoder #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .nibble  (shown_nib),
        .segment (segment)
    );

endmodule

// File: tb/tb_seg_counter_mux.sv
// Scoreboard bench: stimulus pushes expected states, a monitor pops and compares them.
// Three instances: decimal, decimal active-low, and hex (own load strobe).
module tb_seg_counter_mux;

    logic       clk = 1'b0;
    logic       rst, en, up, load, load_hex;
    logic [7:0] load_val, load_val_hex;

    logic [7:0] value_m, value_a, value_h;
    logic [6:0] seg_m, seg_a, seg_h;
    logic [1:0] sel_m, sel_a, sel_h;
    logic       wrap_m, wrap_a, wrap_h;

    always #5 clk = ~clk;

    seg_counter_mux #(.DIGITS(2), .BASE(10), .TICK_DIV(2), .SCAN_DIV(1), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .value(value_m), .segment(seg_m), .digit_sel(sel_m), .wrap(wrap_m));

    seg_counter_mux #(.DIGITS(2), .BASE(10), .TICK_DIV(2), .SCAN_DIV(1), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .value(value_a), .segment(seg_a), .digit_sel(sel_a), .wrap(wrap_a));

    seg_counter_mux #(.DIGITS(2), .BASE(16), .TICK_DIV(2), .SCAN_DIV(1), .ACTIVE_LOW(1'b0)) dut_hex (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load_hex), .load_val(load_val_hex),
        .value(value_h), .segment(seg_h), .digit_sel(sel_h), .wrap(wrap_h));

    typedef struct {
        int         due;
        int         id;
        string      name;
        logic [7:0] value;
        logic [6:0] seg;
        logic [1:0] sel;
        logic       wrap;
        logic [3:0] mask;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    event       sample_ev;
    logic [6:0] glyph [16];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic push_expect(input string name, input int id, input logic [7:0] v,
                               input logic [6:0] s, input logic [1:0] sl, input logic w,
                               input logic [3:0] mask);
        exp_t e;
        e.due = cyc; e.id = id; e.name = name; e.value = v;
        e.seg = s; e.sel = sl; e.wrap = w; e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input logic [7:0] lv);
        rst = r; en = e; up = u; load = l; load_val = lv;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [7:0] av;
        logic [6:0] as;
        logic [1:0] asl;
        logic       aw;
        case (e.id)
            0:       begin av = value_m; as = seg_m; asl = sel_m; aw = wrap_m; end
            1:       begin av = value_a; as = seg_a; asl = sel_a; aw = wrap_a; end
            default: begin av = value_h; as = seg_h; asl = sel_h; aw = wrap_h; end
        endcase
        if (e.mask[0]) begin
            checks++;
            if (av !== e.value) begin
                errors++;
                $display("[TB] FAIL %s value (dut%0d cyc %0d): got %h want %h", e.name, e.id, cyc, av, e.value);
            end
        end
        if (e.mask[1]) begin
            checks++;
            if (as !== e.seg) begin
                errors++;
                $display("[TB] FAIL %s segment (dut%0d cyc %0d): got %h want %h", e.name, e.id, cyc, as, e.seg);
            end
        end
        if (e.mask[2]) begin
            checks++;
            if (asl !== e.sel) begin
                errors++;
                $display("[TB] FAIL %s digit_sel (dut%0d cyc %0d): got %b want %b", e.name, e.id, cyc, asl, e.sel);
            end
        end
        if (e.mask[3]) begin
            checks++;
            if (aw !== e.wrap) begin
                errors++;
                $display("[TB] FAIL %s wrap (dut%0d cyc %0d): got %b want %b", e.name, e.id, cyc, aw, e.wrap);
            end
        end
    endtask

    // Monitor: compares every queued expectation once its cycle is presented.
    initial begin
        forever begin
            @(negedge clk or sample_ev);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                cur = sb.pop_front();
                checkOutput(cur);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, k, n, d;
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        load_hex = 1'b0;
        load_val_hex = 8'h00;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        step(3);
        push_expect("reset", 0, 8'h00, 7'h3F, 2'b01, 1'b0, 4'hF);
        push_expect("reset_al", 1, 8'h00, 7'h40, 2'b10, 1'b0, 4'hF);

        // Free count from zero: value steps every second edge, scan toggles every edge.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        c0 = cyc;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            k = cyc - c0;
            n = (k - 1) / 2;
            d = (k % 2 == 1) ? n / 10 : n % 10;
            push_expect("count_up", 0, bcd(k / 2), glyph[d],
                        (k % 2 == 1) ? 2'b10 : 2'b01, 1'b0, 4'hF);
            if (i == 20) begin
                push_expect("count_up_al", 1, bcd(k / 2), ~glyph[d], 2'b10, 1'b0, 4'hF);
            end
        end

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h98);
        step(1); push_expect("load98", 0, 8'h98, 7'h00, 2'b00, 1'b0, 4'b1001);
        load = 1'b0;
        step(1); push_expect("hold98", 0, 8'h98, 7'h00, 2'b00, 1'b0, 4'b1001);
        step(1); push_expect("up99", 0, 8'h99, 7'h00, 2'b00, 1'b0, 4'b1001);
        step(1); push_expect("hold99", 0, 8'h99, 7'h00, 2'b00, 1'b0, 4'b1001);
        step(1); push_expect("wrap_up", 0, 8'h00, 7'h00, 2'b00, 1'b1, 4'b1001);
        step(1); push_expect("wrap_up_end", 0, 8'h00, 7'h00, 2'b00, 1'b0, 4'b1001);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        step(1); push_expect("load00", 0, 8'h00, 7'h00, 2'b00, 1'b0, 4'b1001);
        load = 1'b0;
        step(1); push_expect("hold00", 0, 8'h00, 7'h00, 2'b00, 1'b0, 4'b1001);
        step(1); push_expect("wrap_down", 0, 8'h99, 7'h00, 2'b00, 1'b1, 4'b1001);
        step(1); push_expect("wrap_down_end", 0, 8'h99, 7'h00, 2'b00, 1'b0, 4'b1001);
        step(1); push_expect("down98", 0, 8'h98, 7'h00, 2'b00, 1'b0, 4'b1001);

        step(1); push_expect("pre_tick", 0, 8'h98, 7'h00, 2'b00, 1'b0, 4'b0001);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h42);
        step(1); push_expect("load_over_tick", 0, 8'h42, 7'h00, 2'b00, 1'b0, 4'b0001);
        load = 1'b0;
        step(1); push_expect("presc_restart", 0, 8'h42, 7'h00, 2'b00, 1'b0, 4'b0001);
        step(1); push_expect("after_restart", 0, 8'h43, 7'h00, 2'b00, 1'b0, 4'b0001);

        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            k = cyc - c0;
            push_expect("en_hold", 0, 8'h43, 7'h00, (k % 2 == 1) ? 2'b10 : 2'b01, 1'b0, 4'b0101);
        end

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h56);
        step(1); push_expect("load56", 0, 8'h56, 7'h00, 2'b00, 1'b0, 4'b0001);
        load = 1'b0;
        step(2); push_expect("at57", 0, 8'h57, 7'h00, 2'b00, 1'b0, 4'b0001);

        // Asynchronous reset between edges must show up before the next clock edge.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        push_expect("async_rst", 0, 8'h00, 7'h3F, 2'b01, 1'b0, 4'hF);
        push_expect("async_rst_al", 1, 8'h00, 7'h40, 2'b10, 1'b0, 4'hF);
        -> sample_ev;

        step(1);
        rst = 1'b0;
        step(1); push_expect("post_rst_wait", 0, 8'h00, 7'h00, 2'b00, 1'b0, 4'b0001);
        step(1); push_expect("post_rst_tick", 0, 8'h01, 7'h00, 2'b00, 1'b0, 4'b0001);

        load_hex = 1'b1;
        load_val_hex = 8'hFE;
        step(1); push_expect("hex_loadFE", 2, 8'hFE, 7'h00, 2'b00, 1'b0, 4'b0001);
        load_hex = 1'b0;
        step(1); push_expect("hex_FE_E", 2, 8'hFE, 7'h79, 2'b01, 1'b0, 4'b0111);
        step(1); push_expect("hex_FF", 2, 8'hFF, 7'h71, 2'b10, 1'b0, 4'hF);
        step(1); push_expect("hex_FF_F", 2, 8'hFF, 7'h71, 2'b01, 1'b0, 4'b0111);
        step(1); push_expect("hex_wrap", 2, 8'h00, 7'h71, 2'b10, 1'b1, 4'hF);
        step(1); push_expect("hex_wrap_end", 2, 8'h00, 7'h3F, 2'b01, 1'b0, 4'hF);

        step(1);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
